// File: rtl/register_file_pkg.sv
// Shared datapath definitions for the register file and the upstream
// RegDst mux: register count, register address width and default width.
package register_file_pkg;

  localparam int NUM_REGS   = 32;
  localparam int ADDR_W     = 5;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/register_file_reg_write_decoder.sv
// reg_write_decoder: 5-to-32 one-hot write-enable decoder.
//   reg_write  in   global write enable; all outputs 0 when low
//   write_reg  in   destination register address
//   write_en   out  one-hot enable per register; bit 0 is never set
module reg_write_decoder
  import register_file_pkg::*;
(
  input  logic                reg_write,
  input  logic [ADDR_W-1:0]   write_reg,
  output logic [NUM_REGS-1:0] write_en
);

  always_comb begin
    write_en = '0;
    if (reg_write) begin
      write_en[write_reg] = 1'b1;
    end
    // Register 0 is hard-wired to zero, so a write to it is simply dropped.
    write_en[0] = 1'b0;
  end

endmodule

// File: rtl/register_file.sv
// register_file: 32 x DATA_W register array, two combinational read ports,
// one synchronous write port, synchronous active-high clear.
//   clk                     in   rising-edge clock
//   reset                   in   synchronous clear of all registers
//   read_reg1 / read_reg2   in   read addresses
//   write_reg               in   write address
//   write_data              in   write data
//   reg_write               in   write enable
//   read_data1 / read_data2 out  read data (register 0 always reads 0)
// BYPASS=1 forwards the in-flight write to a read of the same register.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] write_en;
  logic                fwd_ok;
  logic [DATA_W-1:0]   rd1;
  logic [DATA_W-1:0]   rd2;

  reg_write_decoder u_dec (
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_en  (write_en)
  );

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (write_en[i]) begin
        regs_d[i] = write_data;
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Forwarding is suppressed during reset because the write will be lost.
  assign fwd_ok = (BYPASS != 0) && !reset && reg_write && (write_reg != '0);

  always_comb begin
    rd1 = regs_q[read_reg1];
    if (read_reg1 == '0) begin
      rd1 = '0;
    end else if (fwd_ok && (write_reg == read_reg1)) begin
      rd1 = write_data;
    end
  end

  always_comb begin
    rd2 = regs_q[read_reg2];
    if (read_reg2 == '0) begin
      rd2 = '0;
    end else if (fwd_ok && (write_reg == read_reg2)) begin
      rd2 = write_data;
    end
  end

  assign read_data1 = rd1;
  assign read_data2 = rd2;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] rd1_b0, rd2_b0, rd1_b1, rd2_b1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [32];

  register_file #(.DATA_W(32), .BYPASS(0)) dut_b0 (
    .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(rd1_b0), .read_data2(rd2_b0)
  );

  register_file #(.DATA_W(32), .BYPASS(1)) dut_b1 (
    .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(rd1_b1), .read_data2(rd2_b1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit bypass);
    if (addr == 0) return 32'h0;
    if (bypass && !reset && reg_write && write_reg != 0 && write_reg == addr) return write_data;
    return model[addr];
  endfunction

  task automatic check_reads(input string tag);
    #1;
    check({tag, ".b0.rd1"}, rd1_b0, exp_read(read_reg1, 0));
    check({tag, ".b0.rd2"}, rd2_b0, exp_read(read_reg2, 0));
    check({tag, ".b1.rd1"}, rd1_b1, exp_read(read_reg1, 1));
    check({tag, ".b1.rd2"}, rd2_b1, exp_read(read_reg2, 1));
  endtask

  // Advance one rising edge and apply the sampled controls to the model.
  task automatic edge_update();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (reg_write && write_reg != 0) begin
      model[write_reg] = write_data;
    end
    #1;
  endtask

  task automatic cycle(input string tag);
    check_reads(tag);
    edge_update();
  endtask

  initial begin
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    edge_update();
    reset = 1'b0;

    // Reset sweep: everything reads 0.
    for (int a = 0; a < 32; a++) begin
      read_reg1 = 5'(a); read_reg2 = 5'(31 - a);
      #1;
      check("rst_sweep.rd1", rd1_b0, 32'h0);
      check("rst_sweep.rd2", rd2_b1, 32'h0);
    end

    // Basic write then read.
    reg_write = 1'b1; write_reg = 5'd9; write_data = 32'hDEADBEEF;
    edge_update();
    reg_write = 1'b0; read_reg1 = 5'd9; read_reg2 = 5'd8;
    #1;
    check("w9.rd1", rd1_b0, 32'hDEADBEEF);
    check("w9.rd2", rd2_b0, 32'h0);
    check("w9.b1.rd1", rd1_b1, 32'hDEADBEEF);

    // Write to register 0 is discarded.
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    cycle("zero_pre");
    reg_write = 1'b0;
    #1;
    check("zero.b0", rd1_b0, 32'h0);
    check("zero.b1", rd2_b1, 32'h0);

    // Enable low leaves register 5 unchanged.
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h00000055;
    edge_update();
    reg_write = 1'b0; write_data = 32'h12345678; read_reg1 = 5'd5; read_reg2 = 5'd5;
    edge_update();
    #1;
    check("en_low.rd1", rd1_b0, 32'h00000055);
    check("en_low.rd2", rd2_b1, 32'h00000055);

    // Same-cycle read/write of register 7.
    reg_write = 1'b1; write_reg = 5'd7; write_data = 32'h1;
    edge_update();
    write_data = 32'h2; read_reg1 = 5'd7; read_reg2 = 5'd7;
    #1;
    check("rw7.pre.b0", rd1_b0, 32'h1);
    check("rw7.pre.b1", rd1_b1, 32'h2);
    check("rw7.pre.b1p2", rd2_b1, 32'h2);
    cycle("rw7");
    reg_write = 1'b0;
    #1;
    check("rw7.post.b0", rd1_b0, 32'h2);
    check("rw7.post.b1", rd2_b1, 32'h2);

    // Glitch between edges has no effect: enable drops before the edge.
    reg_write = 1'b1; write_reg = 5'd4; write_data = 32'hCAFEF00D; read_reg1 = 5'd4;
    #2;
    reg_write = 1'b0;
    edge_update();
    #1;
    check("glitch.rd1", rd1_b0, 32'h0);

    // Reset beats a simultaneous write; bypass is suppressed during reset.
    reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hA5A5A5A5;
    read_reg1 = 5'd3; read_reg2 = 5'd9; reset = 1'b1;
    #1;
    check("rst_wr.pre.b1", rd1_b1, 32'h0);
    check("rst_wr.pre.b1r9", rd2_b1, 32'hDEADBEEF);
    cycle("rst_wr");
    reset = 1'b0; reg_write = 1'b0;
    #1;
    check("rst_wr.post.b0", rd1_b0, 32'h0);
    check("rst_wr.post.r9", rd2_b0, 32'h0);
    check("rst_wr.post.b1", rd1_b1, 32'h0);

    // Randomised traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 39) == 0);
      reg_write  = $urandom_range(0, 3) != 0;
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 4) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
      cycle("rand");
    end

    reset = 1'b0; reg_write = 1'b0;
    for (int a = 0; a < 32; a++) begin
      read_reg1 = 5'(a); read_reg2 = 5'(a);
      check_reads("final_sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter BYPASS, default 0: 1 forwards same-cycle write data to the read ports; 0 returns the stored value.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port read_reg1  input  5  read port 1 address (instruction rs field).
REQ-006 Port read_reg2  input  5  read port 2 address (instruction rt field).
REQ-007 Port write_reg  input  5  write address, driven by the upstream 5-bit RegDst 2:1 mux (rt/rd select).
REQ-008 Port write_data  input  DATA_W  data to be written.
REQ-009 Port reg_write  input  1  write enable.
REQ-010 Port read_data1  output  DATA_W  contents of register read_reg1.
REQ-011 Port read_data2  output  DATA_W  contents of register read_reg2.

Function
REQ-012 Storage SHALL be 32 registers of DATA_W bits, indexed 0-31.
REQ-013 Reads SHALL be combinational: read_dataN follows read_regN and array contents with zero clock latency.
REQ-014 Register 0 SHALL always read as 0, regardless of any write.
REQ-015 On rising clk with reset=0, reg_write=1, write_reg!=0: register[write_reg] SHALL take write_data; new value visible on reads immediately after that edge.
REQ-016 reg_write=0 SHALL leave every register unchanged; write_reg=0 with reg_write=1 SHALL be discarded.
REQ-017 write_reg, write_data and reg_write SHALL be sampled only at the rising edge; changes between edges SHALL have no effect on state.
REQ-018 BYPASS=0: read of the register being written in the same cycle SHALL return the pre-edge stored value until the edge.
REQ-019 BYPASS=1: when reg_write=1, write_reg!=0, write_reg==read_regN, read_dataN SHALL equal write_data combinationally; register 0 is never bypassed.
REQ-020 Both read ports addressing the same register SHALL return identical values.
REQ-021 Only one write per cycle; no write conflict arbitration required.
REQ-022 Read ports SHALL never produce X for any 5-bit address after first reset.

Reset
REQ-023 reset=1 at a rising edge SHALL clear all 32 registers to 0; read_data1/read_data2 are 0 for every address afterwards.
REQ-024 reset SHALL take priority over a simultaneous write; the write is lost.
REQ-025 Reset asserted mid-program SHALL clear all state in one edge; no multi-cycle reset sequence.
REQ-026 With BYPASS=1 and reset=1, bypass forwarding SHALL be suppressed; reads return stored values.

Structure
REQ-027 Register count (32), address width (5) and DATA_W default SHALL be defined in the shared datapath defines header, also used by the RegDst mux.
REQ-028 One sub-module is natural: reg_write_decoder, 5-to-32 one-hot write-enable decoder gated by reg_write with output bit 0 forced to 0.
REQ-029 Read muxing SHALL be inline array indexing; no per-port sub-module.

Verification
REQ-030 Reset: reset=1 one edge, then sweep read_reg1/2 over 0-31 -> all reads 0.
REQ-031 Write/read: write 32'hDEADBEEF to reg 9, next cycle read_reg1=9 -> read_data1=32'hDEADBEEF, read_data2 (reg 8)=0.
REQ-032 Zero register: reg_write=1, write_reg=0, write_data=32'hFFFFFFFF -> read of reg 0 returns 0 after the edge.
REQ-033 Enable low: reg_write=0, write_reg=5, write_data=32'h12345678 -> reg 5 stays at previous value.
REQ-034 Same-cycle read/write reg 7 (old 32'h1, new 32'h2): BYPASS=0 -> 32'h1 before edge, 32'h2 after; BYPASS=1 -> 32'h2 before edge.
REQ-035 Reset vs write: reset=1 and reg_write=1 to reg 3 with 32'hA5A5A5A5 on the same edge -> reg 3 reads 0.
